// File: rtl/prod_accum_pkg.sv
// Shared types and default sizing for the product accumulator slice.
package prod_accum_pkg;

   localparam int N_PROD_DEF = 4;
   localparam int ACC_W_DEF  = 20;
   localparam int PROD_W     = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_e;

   // Width of a counter that must reach n inclusive.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/prod_accum_if.sv
// Product-in / sum-out handshake bundle; master is the producer/consumer side.
interface prod_accum_if
   import prod_accum_pkg::*;
#(
   parameter int N_PROD = N_PROD_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int CNT_W  = cnt_width(N_PROD)
) ();

   logic              clr;
   logic [PROD_W-1:0] prod;
   logic              prod_valid;
   logic              prod_ready;
   logic [ACC_W-1:0]  sum;
   logic              sum_valid;
   logic              sum_ready;
   logic [CNT_W-1:0]  cnt;
   logic              ovf;

   modport master (
      output clr, prod, prod_valid, sum_ready,
      input  prod_ready, sum, sum_valid, cnt, ovf
   );

   modport slave (
      input  clr, prod, prod_valid, sum_ready,
      output prod_ready, sum, sum_valid, cnt, ovf
   );

endinterface

// File: rtl/prod_accum_sat_add.sv
// W-bit adder with carry-out; PROD_ACCUM_SAT_EN clamps the result to all-ones on carry.
module sat_add #(
   parameter int W = 20
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] s_o,
   output logic         co_o
);

   logic [W:0] raw;

   assign raw  = {1'b0, a_i} + {1'b0, b_i};
   assign co_o = raw[W];

`ifdef PROD_ACCUM_SAT_EN
   assign s_o = raw[W] ? {W{1'b1}} : raw[W-1:0];
`else
   assign s_o = raw[W-1:0];
`endif

endmodule

// File: rtl/prod_accum.sv
// Sums blocks of N_PROD unsigned products and holds each sum until taken.
// Optional saturation on overflow: define PROD_ACCUM_SAT_EN.
module prod_accum
   import prod_accum_pkg::*;
#(
   parameter int N_PROD = N_PROD_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   prod_accum_if.slave bus
);

   localparam int               CNT_W    = cnt_width(N_PROD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PROD);

   state_e           state_q;
   logic [ACC_W-1:0] acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_q;
   logic             sv_q;
   logic             rdy_q;

   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] add_s;
   logic             add_co;
   logic [CNT_W-1:0] cnt_inc;
   logic             xfer;

   assign prod_ext = ACC_W'(bus.prod);
   assign cnt_inc  = cnt_q + CNT_W'(1);
   // rdy_q is low only in HOLD and during reset, so it doubles as the accept gate.
   assign xfer     = bus.prod_valid & rdy_q;

   sat_add #(.W(ACC_W)) u_add (
      .a_i  (acc_q),
      .b_i  (prod_ext),
      .s_o  (add_s),
      .co_o (add_co)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         sv_q    <= 1'b0;
         rdy_q   <= 1'b0;
      end else if (bus.clr) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         sv_q    <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               rdy_q <= 1'b1;
               if (xfer) begin
                  acc_q <= prod_ext;
                  cnt_q <= CNT_W'(1);
                  ovf_q <= 1'b0;
                  if (N_PROD == 1) begin
                     state_q <= HOLD;
                     sv_q    <= 1'b1;
                     rdy_q   <= 1'b0;
                  end else begin
                     state_q <= ACCUM;
                  end
               end
            end
            ACCUM: begin
               rdy_q <= 1'b1;
               if (xfer) begin
                  acc_q <= add_s;
                  cnt_q <= cnt_inc;
                  ovf_q <= ovf_q | add_co;
                  if (cnt_inc == CNT_LAST) begin
                     state_q <= HOLD;
                     sv_q    <= 1'b1;
                     rdy_q   <= 1'b0;
                  end
               end
            end
            HOLD: begin
               // ovf survives the handshake so software can still see it while idle.
               if (bus.sum_ready) begin
                  state_q <= IDLE;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  sv_q    <= 1'b0;
                  rdy_q   <= 1'b1;
               end else begin
                  rdy_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               acc_q   <= '0;
               cnt_q   <= '0;
               ovf_q   <= 1'b0;
               sv_q    <= 1'b0;
               rdy_q   <= 1'b1;
            end
         endcase
      end
   end

   assign bus.prod_ready = rdy_q;
   assign bus.sum        = acc_q;
   assign bus.sum_valid  = sv_q;
   assign bus.cnt        = cnt_q;
   assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench: default, ACC_W=17 and N_PROD=1 instances of prod_accum.
module tb_prod_accum;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   prod_accum_if #(.N_PROD(4), .ACC_W(20)) b0 ();
   prod_accum_if #(.N_PROD(4), .ACC_W(17)) b1 ();
   prod_accum_if #(.N_PROD(1), .ACC_W(20)) b2 ();

   prod_accum #(.N_PROD(4), .ACC_W(20)) u0 (.clk(clk), .rst(rst), .bus(b0));
   prod_accum #(.N_PROD(4), .ACC_W(17)) u1 (.clk(clk), .rst(rst), .bus(b1));
   prod_accum #(.N_PROD(1), .ACC_W(20)) u2 (.clk(clk), .rst(rst), .bus(b2));

   typedef struct {
      logic        clr;
      logic        pv;
      logic [15:0] prod;
      logic        sr;
      logic        rdy;
      logic        sv;
      logic [19:0] sum;
      logic [2:0]  cnt;
      logic        ovf;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(int c, int pv, int p, int sr,
                               int rdy, int sv, int s, int n, int o);
      vec_t r;
      r.clr = c[0];   r.pv  = pv[0];  r.prod = p[15:0]; r.sr  = sr[0];
      r.rdy = rdy[0]; r.sv  = sv[0];  r.sum  = s[19:0]; r.cnt = n[2:0];
      r.ovf = o[0];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk0(input string nm, input vec_t v);
      chk({nm, ".rdy"}, 32'(b0.prod_ready), 32'(v.rdy));
      chk({nm, ".sv"},  32'(b0.sum_valid),  32'(v.sv));
      chk({nm, ".sum"}, 32'(b0.sum),        32'(v.sum));
      chk({nm, ".cnt"}, 32'(b0.cnt),        32'(v.cnt));
      chk({nm, ".ovf"}, 32'(b0.ovf),        32'(v.ovf));
   endtask

   task automatic apply(input vec_t v, input string nm);
      b0.clr        = v.clr;
      b0.prod_valid = v.pv;
      b0.prod       = v.prod;
      b0.sum_ready  = v.sr;
      tick();
      chk0(nm, v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [16:0] exp3, exp4;
      rst = 1'b0;
      b0.clr = 0; b0.prod_valid = 0; b0.prod = 0; b0.sum_ready = 0;
      b1.clr = 0; b1.prod_valid = 0; b1.prod = 0; b1.sum_ready = 0;
      b2.clr = 0; b2.prod_valid = 0; b2.prod = 0; b2.sum_ready = 0;
      #2;
      chk0("reset", mk(0,0,0,0, 0,0,0,0,0));
      #10 rst = 1'b1;

      // clr, pv, prod, sr | rdy, sv, sum, cnt, ovf
      tbl.push_back(mk(0,0,0,0,    1,0,0,0,0));
      tbl.push_back(mk(0,1,1,1,    1,0,1,1,0));
      tbl.push_back(mk(0,1,25,1,   1,0,26,2,0));
      tbl.push_back(mk(0,1,6,1,    1,0,32,3,0));
      tbl.push_back(mk(0,1,100,1,  0,1,132,4,0));
      tbl.push_back(mk(0,0,0,1,    1,0,0,0,0));
      tbl.push_back(mk(0,1,10,0,   1,0,10,1,0));
      tbl.push_back(mk(0,1,20,0,   1,0,30,2,0));
      tbl.push_back(mk(0,1,30,0,   1,0,60,3,0));
      tbl.push_back(mk(0,1,40,0,   0,1,100,4,0));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(0,1,77,0, 0,1,100,4,0));
      tbl.push_back(mk(0,1,77,1,   1,0,0,0,0));
      tbl.push_back(mk(0,1,9,0,    1,0,9,1,0));
      tbl.push_back(mk(1,1,50,0,   1,0,0,0,0));
      tbl.push_back(mk(0,1,1,0,    1,0,1,1,0));
      tbl.push_back(mk(0,0,55,0,   1,0,1,1,0));
      tbl.push_back(mk(0,1,1,0,    1,0,2,2,0));
      tbl.push_back(mk(0,1,1,0,    1,0,3,3,0));
      tbl.push_back(mk(0,1,1,0,    0,1,4,4,0));
      tbl.push_back(mk(1,0,0,1,    1,0,0,0,0));

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], $sformatf("vec%0d", i));

      // Reset mid-block, then a fresh block.
      apply(mk(0,1,5,0, 1,0,5,1,0),  "rst.a");
      apply(mk(0,1,7,0, 1,0,12,2,0), "rst.b");
      #2 rst = 1'b0;
      #1 chk0("rst.async", mk(0,0,0,0, 0,0,0,0,0));
      #1 rst = 1'b1;
      apply(mk(0,1,99,0, 1,0,0,0,0),  "rst.first");
      apply(mk(0,1,2,0,  1,0,2,1,0),  "rst.p2");
      apply(mk(0,1,3,0,  1,0,5,2,0),  "rst.p3");
      apply(mk(0,1,4,0,  1,0,9,3,0),  "rst.p4");
      apply(mk(0,1,5,0,  0,1,14,4,0), "rst.p5");
      apply(mk(0,0,0,1,  1,0,0,0,0),  "rst.done");

      // ACC_W=17 overflow.
`ifdef PROD_ACCUM_SAT_EN
      exp3 = 17'h1FFFF; exp4 = 17'h1FFFF;
`else
      exp3 = 17'h0FFFD; exp4 = 17'h1FFFC;
`endif
      b1.prod_valid = 1; b1.prod = 16'hFFFF;
      tick();
      chk("w17.s1", 32'(b1.sum), 32'h0FFFF);
      chk("w17.o1", 32'(b1.ovf), 0);
      tick();
      chk("w17.s2", 32'(b1.sum), 32'h1FFFE);
      chk("w17.o2", 32'(b1.ovf), 0);
      tick();
      chk("w17.s3", 32'(b1.sum), 32'(exp3));
      chk("w17.o3", 32'(b1.ovf), 1);
      tick();
      chk("w17.s4",  32'(b1.sum),       32'(exp4));
      chk("w17.o4",  32'(b1.ovf),       1);
      chk("w17.sv",  32'(b1.sum_valid), 1);
      chk("w17.cnt", 32'(b1.cnt),       4);
      b1.prod_valid = 0; b1.sum_ready = 1;
      tick();
      chk("w17.sv0",  32'(b1.sum_valid), 0);
      chk("w17.keep", 32'(b1.ovf),       1);
      b1.prod_valid = 1; b1.prod = 16'd3; b1.sum_ready = 0;
      tick();
      chk("w17.clro", 32'(b1.ovf), 0);
      chk("w17.nsum", 32'(b1.sum), 3);
      b1.prod_valid = 0;

      // N_PROD=1: every transfer completes a block.
      b2.prod_valid = 1; b2.prod = 16'h0019;
      tick();
      chk("n1.sum", 32'(b2.sum),        25);
      chk("n1.sv",  32'(b2.sum_valid),  1);
      chk("n1.cnt", 32'(b2.cnt),        1);
      chk("n1.rdy", 32'(b2.prod_ready), 0);
      b2.prod_valid = 0; b2.sum_ready = 1;
      tick();
      chk("n1.sv0",  32'(b2.sum_valid),  0);
      chk("n1.rdy1", 32'(b2.prod_ready), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 Parameter: N_PROD, 4, number of products summed per block (>=1).
REQ-002 Parameter: ACC_W, 20, accumulator/sum width in bits (>=16).
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: clr  input  1  synchronous block abort; discards partial sum.
REQ-006 Port: prod  input  16  unsigned product from the 8x8 multiplier.
REQ-007 Port: prod_valid  input  1  prod is valid this cycle.
REQ-008 Port: prod_ready  output  1  block can accept prod this cycle.
REQ-009 Port: sum  output  ACC_W  completed block sum.
REQ-010 Port: sum_valid  output  1  sum holds a completed block.
REQ-011 Port: sum_ready  input  1  downstream accepts sum.
REQ-012 Port: cnt  output  $clog2(N_PROD+1)  products accepted in current block.
REQ-013 Port: ovf  output  1  sticky overflow flag for current block.

Function
REQ-014 FSM states SHALL be IDLE, ACCUM, HOLD.
REQ-015 Product transfer SHALL occur on a rising edge with prod_valid=1 and prod_ready=1.
REQ-016 prod_ready SHALL be 1 in IDLE and ACCUM, 0 in HOLD (no bypass).
REQ-017 IDLE + transfer: acc<=prod zero-extended, cnt<=1, ovf<=0; go ACCUM, or HOLD if N_PROD=1.
REQ-018 ACCUM + transfer: acc<=acc+prod, cnt<=cnt+1; when new cnt equals N_PROD go HOLD.
REQ-019 ACCUM without transfer SHALL hold acc, cnt, ovf unchanged (no timeout).
REQ-020 sum_valid SHALL rise on the edge following the N_PROD-th transfer (1-cycle latency); sum=acc.
REQ-021 In HOLD, sum, sum_valid, cnt, ovf SHALL remain stable until sum_ready=1.
REQ-022 HOLD + sum_ready=1: next edge go IDLE, sum_valid<=0, acc<=0, cnt<=0; ovf retained until next block's first transfer.
REQ-023 Sum width rule: addition SHALL be ACC_W+1 bits internally; carry-out sets ovf.
REQ-024 clr=1 SHALL force IDLE, acc=0, cnt=0, ovf=0, sum_valid=0 on next edge, with priority over any simultaneous transfer or sum handshake (that product is dropped).

Reset
REQ-025 rst=0 SHALL immediately force IDLE, acc=0, cnt=0, ovf=0, sum_valid=0, prod_ready=0 (prod_ready=1 from first edge after release).
REQ-026 Reset mid-block SHALL discard the partial sum; no stale value appears after release.

Configuration
REQ-027 Macro PROD_ACCUM_SAT_EN defined: on carry-out acc SHALL saturate to all-ones and stay there for the block; ovf=1.
REQ-028 Macro undefined: acc SHALL wrap modulo 2^ACC_W; ovf=1 on any carry-out.

Structure
REQ-029 Package prod_accum_pkg SHALL hold the state enum typedef and the N_PROD/ACC_W default constants.
REQ-030 Sub-module sat_add (ACC_W-bit adder, carry-out, optional saturation under PROD_ACCUM_SAT_EN) SHALL implement the add.

Verification
REQ-031 Defaults; products 1,25,6,100 back-to-back, sum_ready=1 -> sum=132, sum_valid=1 one cycle after 4th, ovf=0, then IDLE.
REQ-032 Block complete, sum_ready=0 for 5 cycles with prod_valid=1 -> prod_ready=0, sum stable at value, no product consumed; handshake -> IDLE next edge.
REQ-033 ACC_W=17, four 0xFFFF -> wrap build: sum=0x1FFFC, ovf=1; PROD_ACCUM_SAT_EN build: sum=0x1FFFF, ovf=1.
REQ-034 Two products (5,7) accepted, rst pulsed low -> all outputs zero immediately; next block 2,3,4,5 -> sum=14.
REQ-035 After product 9, clr=1 together with prod_valid=1, prod=50 -> cnt=0, product 50 dropped; next block 1,1,1,1 -> sum=4.
REQ-036 N_PROD=1; prod=0x0019 -> sum=25, sum_valid one cycle after transfer.
